// File: rtl/jtagcdc_resp.sv
`default_nettype none
// ============================================================================
//  Module      : jtagcdc_resp
//  Description : Response-return half of the JTAG<->system DMI clock-domain
//                crossing, running in the JTAG (TCK) domain. It receives the
//                DMI read-data/error word from the system domain over a
//                4-phase req/ack handshake and hands it to the DTM as a
//                valid/ready transfer. It also tracks the outstanding request
//                and provides the busy and sticky overrun bits for dmistat.
//
//  Ports       : i_clk            JTAG-domain clock (TCK)
//                i_nrst           synchronous active-low reset
//                i_sys_resp_valid async request level from the system domain
//                i_sys_resp_data  async read data, stable while valid is high
//                i_sys_resp_error async error flag, stable while valid is high
//                o_sys_resp_ack   registered ack level back to system domain
//                i_dmi_req_sent   pulse: DTM issued a request
//                i_dmi_reset      pulse: clear sticky overrun
//                i_dmi_hardreset  pulse: abort the current transaction
//                o_dmi_resp_valid response available to the DTM
//                i_dmi_resp_ready DTM accepts the response
//                o_dmi_resp_data  captured read data
//                o_dmi_resp_error captured error flag
//                o_dmi_busy       a request is outstanding
//                o_dmi_overrun    sticky: request issued while busy
//
//  Revision    : 1.0  initial release
// ============================================================================
module jtagcdc_resp #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_sys_resp_valid,
    input  logic [31:0] i_sys_resp_data,
    input  logic        i_sys_resp_error,
    output logic        o_sys_resp_ack,
    input  logic        i_dmi_req_sent,
    input  logic        i_dmi_reset,
    input  logic        i_dmi_hardreset,
    output logic        o_dmi_resp_valid,
    input  logic        i_dmi_resp_ready,
    output logic [31:0] o_dmi_resp_data,
    output logic        o_dmi_resp_error,
    output logic        o_dmi_busy,
    output logic        o_dmi_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESP     = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_n;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sv;

    logic        r_ack,     w_ack_n;
    logic        r_valid,   w_valid_n;
    logic [31:0] r_data,    w_data_n;
    logic        r_error,   w_error_n;
    logic        r_pending, w_pending_n;
    logic        r_overrun, w_overrun_n;
    logic        r_busy,    w_busy_n;
    logic        w_hs;

    // Only the valid level crosses through the synchronizer; data and error
    // are guaranteed stable by the sender while that level is high.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sys_resp_valid};
        end
    end

    assign w_sv = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state   <= ST_IDLE;
            r_ack     <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= 32'd0;
            r_error   <= 1'b0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_ack     <= w_ack_n;
            r_valid   <= w_valid_n;
            r_data    <= w_data_n;
            r_error   <= w_error_n;
            r_pending <= w_pending_n;
            r_overrun <= w_overrun_n;
            r_busy    <= w_busy_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_ack_n     = r_ack;
        w_valid_n   = r_valid;
        w_data_n    = r_data;
        w_error_n   = r_error;
        w_pending_n = r_pending;
        w_overrun_n = r_overrun;
        w_hs        = 1'b0;

        if (i_dmi_hardreset) begin
            w_valid_n   = 1'b0;
            w_pending_n = 1'b0;
            w_overrun_n = 1'b0;
            // With ack raised the sender still has to see the release phase,
            // so park in WAIT_REL until its valid drops.
            w_state_n   = r_ack ? ST_WAIT_REL : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sv) begin
                        w_data_n  = i_sys_resp_data;
                        w_error_n = i_sys_resp_error;
                        w_ack_n   = 1'b1;
                        w_valid_n = 1'b1;
                        w_state_n = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (r_valid && i_dmi_resp_ready) begin
                        w_hs        = 1'b1;
                        w_valid_n   = 1'b0;
                        w_pending_n = 1'b0;
                        w_state_n   = ST_WAIT_REL;
                    end
                end
                ST_WAIT_REL: begin
                    if (!w_sv) begin
                        w_ack_n   = 1'b0;
                        w_state_n = ST_IDLE;
                    end
                end
                default: begin
                    w_state_n = ST_IDLE;
                end
            endcase

            // A request sent in the delivery cycle is a legitimate new request,
            // not an overrun of the one being completed.
            if (i_dmi_req_sent) begin
                w_pending_n = 1'b1;
                if (r_busy && !w_hs) begin
                    w_overrun_n = 1'b1;
                end
            end

            if (i_dmi_reset) begin
                w_overrun_n = 1'b0;
            end
        end
    end

    // Busy is registered from the next-state values so it stays glitch free.
    assign w_busy_n = w_pending_n | (w_state_n == ST_RESP);

    assign o_sys_resp_ack   = r_ack;
    assign o_dmi_resp_valid = r_valid;
    assign o_dmi_resp_data  = r_data;
    assign o_dmi_resp_error = r_error;
    assign o_dmi_busy       = r_busy;
    assign o_dmi_overrun    = r_overrun;

endmodule
`default_nettype wire
